// File: rtl/dcache_txn_monitor.sv
// Passive transaction monitor for the write-back dcache bench.
// Tracks every dcache request port and the ACE snoop channel to completion,
// counts completed reads/writes/snoops, pulses check_done_o when a
// completion has been seen and everything is quiescent, and raises sticky
// protocol-error and timeout flags. It only observes; it drives nothing back.

package dcache_txn_monitor_pkg;
    // Monitor-side view of a dcache request port.
    typedef struct packed {
        logic data_req;
        logic data_we;
        logic kill_req;
    } dcache_req_i_t;

    // Monitor-side view of the cache response to a port.
    typedef struct packed {
        logic data_gnt;
        logic data_rvalid;
    } dcache_req_o_t;

    // ACE CR response bits.
    typedef struct packed {
        logic WasUnique;
        logic IsShared;
        logic PassDirty;
        logic Error;
        logic DataTransfer;
    } cr_resp_t;

    // Interconnect-driven snoop signals: AC valid, CR ready, CD ready.
    typedef struct packed {
        logic ac_valid;
        logic cr_ready;
        logic cd_ready;
    } snoop_req_t;

    // Cache-driven snoop signals: AC ready, CR valid/resp, CD valid/last.
    typedef struct packed {
        logic     ac_ready;
        logic     cr_valid;
        cr_resp_t cr_resp;
        logic     cd_valid;
        logic     cd_last;
    } snoop_resp_t;
endpackage

module dcache_txn_monitor
    import dcache_txn_monitor_pkg::*;
#(
    parameter int unsigned NR_CPU_PORTS  = 3,
    parameter int unsigned TimeoutCycles = 1000,
    parameter int unsigned CntWidth      = 32
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  dcache_req_i_t [NR_CPU_PORTS-1:0]    req_ports_i,
    input  dcache_req_o_t [NR_CPU_PORTS-1:0]    req_ports_o,
    input  snoop_req_t                          snoop_req_i,
    input  snoop_resp_t                         snoop_resp_i,
    output logic                                check_done_o,
    output logic                                proto_err_o,
    output logic                                timeout_o,
    output logic [$clog2(NR_CPU_PORTS+1)-1:0]   err_port_o,
    output logic [CntWidth-1:0]                 rd_cnt_o,
    output logic [CntWidth-1:0]                 wr_cnt_o,
    output logic [CntWidth-1:0]                 snp_cnt_o
);
    localparam int unsigned NT = NR_CPU_PORTS + 1;          // ports + snoop tracker
    localparam int unsigned EW = $clog2(NR_CPU_PORTS + 1);
    localparam int unsigned PW = $clog2(NR_CPU_PORTS + 1);
    localparam int unsigned TW = $clog2(TimeoutCycles + 1);

    localparam logic [1:0] P_IDLE = 2'd0, P_WAIT_GNT = 2'd1, P_WAIT_RD = 2'd2;
    localparam logic [1:0] S_IDLE = 2'd0, S_CR = 2'd1, S_CD = 2'd2;

    logic [NR_CPU_PORTS-1:0] rd_done, wr_done;
    logic                    snp_done;
    logic [NT-1:0]           err_vec, idle_next, tmo_hit;

    for (genvar gi = 0; gi < NR_CPU_PORTS; gi++) begin : g_port
        logic [1:0]    state_q, state_d;
        logic          we_q, we_d;
        logic [TW-1:0] tmo_q, tmo_d;
        logic          rd_done_d, wr_done_d, err_d;
        logic          req, gnt, rvalid, kill;

        assign req    = req_ports_i[gi].data_req;
        assign kill   = req_ports_i[gi].kill_req;
        assign gnt    = req_ports_o[gi].data_gnt;
        assign rvalid = req_ports_o[gi].data_rvalid;

        // Port FSM: follow req/gnt/rvalid, flag stray handshakes, run the timeout counter.
        always_comb begin
            state_d   = state_q;
            we_d      = we_q;
            rd_done_d = 1'b0;
            wr_done_d = 1'b0;
            err_d     = 1'b0;
            case (state_q)
                P_IDLE: begin
                    if (rvalid || (gnt && !req)) err_d = 1'b1;
                    if (req && gnt) begin
                        if (req_ports_i[gi].data_we) wr_done_d = 1'b1;
                        else                         state_d   = P_WAIT_RD;
                    end else if (req) begin
                        state_d = P_WAIT_GNT;
                        we_d    = req_ports_i[gi].data_we;
                    end
                end
                P_WAIT_GNT: begin
                    if (!req) begin
                        err_d   = 1'b1;
                        state_d = P_IDLE;
                    end else if (gnt) begin
                        wr_done_d = we_q;
                        state_d   = we_q ? P_IDLE : P_WAIT_RD;
                    end
                end
                P_WAIT_RD: begin
                    // A killed read never returns data worth counting.
                    if (kill) begin
                        state_d = P_IDLE;
                    end else if (rvalid) begin
                        rd_done_d = 1'b1;
                        state_d   = P_IDLE;
                    end
                end
                default: state_d = P_IDLE;
            endcase

            if (state_q == P_IDLE || state_d != state_q) tmo_d = '0;
            else if (tmo_q == TW'(TimeoutCycles))        tmo_d = tmo_q;
            else                                         tmo_d = tmo_q + 1'b1;
        end

        // Port FSM state, latched write flag and timeout counter.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= P_IDLE;
                we_q    <= 1'b0;
                tmo_q   <= '0;
            end else begin
                state_q <= state_d;
                we_q    <= we_d;
                tmo_q   <= tmo_d;
            end
        end

        assign rd_done[gi]   = rd_done_d;
        assign wr_done[gi]   = wr_done_d;
        assign err_vec[gi]   = err_d;
        assign idle_next[gi] = (state_d == P_IDLE);
        assign tmo_hit[gi]   = (tmo_q == TW'(TimeoutCycles));
    end

    logic [1:0]    s_state_q, s_state_d;
    logic [TW-1:0] s_tmo_q, s_tmo_d;
    logic          s_err_d, s_done_d;
    logic          ac_hs, cr_hs, cd_hs;
    logic          unused_cr_bits;

    assign ac_hs = snoop_req_i.ac_valid & snoop_resp_i.ac_ready;
    assign cr_hs = snoop_resp_i.cr_valid & snoop_req_i.cr_ready;
    assign cd_hs = snoop_resp_i.cd_valid & snoop_req_i.cd_ready;
    assign unused_cr_bits = ^{snoop_resp_i.cr_resp.WasUnique, snoop_resp_i.cr_resp.IsShared,
                              snoop_resp_i.cr_resp.PassDirty, snoop_resp_i.cr_resp.Error};

    // Snoop FSM: AC -> CR -> (optional CD burst), with its own timeout counter.
    always_comb begin
        s_state_d = s_state_q;
        s_err_d   = 1'b0;
        s_done_d  = 1'b0;
        case (s_state_q)
            S_IDLE: begin
                if (snoop_resp_i.cd_valid) s_err_d   = 1'b1;
                if (ac_hs)                 s_state_d = S_CR;
            end
            S_CR: begin
                if (snoop_resp_i.cd_valid || ac_hs) s_err_d = 1'b1;
                if (cr_hs) begin
                    if (snoop_resp_i.cr_resp.DataTransfer) begin
                        s_state_d = S_CD;
                    end else begin
                        s_done_d  = 1'b1;
                        s_state_d = S_IDLE;
                    end
                end
            end
            S_CD: begin
                if (ac_hs) s_err_d = 1'b1;
                if (cd_hs && snoop_resp_i.cd_last) begin
                    s_done_d  = 1'b1;
                    s_state_d = S_IDLE;
                end
            end
            default: s_state_d = S_IDLE;
        endcase

        if (s_state_q == S_IDLE || s_state_d != s_state_q) s_tmo_d = '0;
        else if (s_tmo_q == TW'(TimeoutCycles))            s_tmo_d = s_tmo_q;
        else                                               s_tmo_d = s_tmo_q + 1'b1;
    end

    // Snoop FSM state and timeout counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s_state_q <= S_IDLE;
            s_tmo_q   <= '0;
        end else begin
            s_state_q <= s_state_d;
            s_tmo_q   <= s_tmo_d;
        end
    end

    assign snp_done                = s_done_d;
    assign err_vec[NR_CPU_PORTS]   = s_err_d;
    assign idle_next[NR_CPU_PORTS] = (s_state_d == S_IDLE);
    assign tmo_hit[NR_CPU_PORTS]   = (s_tmo_q == TW'(TimeoutCycles));

    logic                pending_q, pending_d, check_done_q, check_done_d;
    logic                proto_err_q, proto_err_d, timeout_q, timeout_d;
    logic                err_seen_q, err_seen_d;
    logic [EW-1:0]       err_port_q, err_port_d, first_idx;
    logic [CntWidth-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d, snp_cnt_q, snp_cnt_d;
    logic [PW-1:0]       rd_n, wr_n;
    logic [NT-1:0]       off_vec;
    logic                any_done, all_idle_next;

    // Aggregate completions into counters and a single quiescence pulse; latch first offender.
    always_comb begin
        rd_n = '0;
        wr_n = '0;
        for (int i = 0; i < int'(NR_CPU_PORTS); i++) begin
            rd_n = rd_n + PW'(rd_done[i]);
            wr_n = wr_n + PW'(wr_done[i]);
        end
        any_done      = (|rd_done) | (|wr_done) | snp_done;
        all_idle_next = &idle_next;
        // A completion seen while anything is still busy is held until all go idle.
        check_done_d  = (pending_q | any_done) & all_idle_next;
        pending_d     = (pending_q | any_done) & ~all_idle_next;
        rd_cnt_d      = rd_cnt_q + CntWidth'(rd_n);
        wr_cnt_d      = wr_cnt_q + CntWidth'(wr_n);
        snp_cnt_d     = snp_cnt_q + CntWidth'(snp_done);
        proto_err_d   = proto_err_q | (|err_vec);
        timeout_d     = timeout_q | (|tmo_hit);

        off_vec   = err_vec | tmo_hit;
        first_idx = '0;
        for (int i = int'(NT) - 1; i >= 0; i--) begin
            if (off_vec[i]) first_idx = EW'(i);
        end
        err_seen_d = err_seen_q | (|off_vec);
        err_port_d = (!err_seen_q && (|off_vec)) ? first_idx : err_port_q;
    end

    // Completion bookkeeping, counters and sticky error state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q    <= 1'b0;
            check_done_q <= 1'b0;
            proto_err_q  <= 1'b0;
            timeout_q    <= 1'b0;
            err_seen_q   <= 1'b0;
            err_port_q   <= '0;
            rd_cnt_q     <= '0;
            wr_cnt_q     <= '0;
            snp_cnt_q    <= '0;
        end else begin
            pending_q    <= pending_d;
            check_done_q <= check_done_d;
            proto_err_q  <= proto_err_d;
            timeout_q    <= timeout_d;
            err_seen_q   <= err_seen_d;
            err_port_q   <= err_port_d;
            rd_cnt_q     <= rd_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
            snp_cnt_q    <= snp_cnt_d;
        end
    end

    assign check_done_o = check_done_q;
    assign proto_err_o  = proto_err_q;
    assign timeout_o    = timeout_q;
    assign err_port_o   = err_port_q;
    assign rd_cnt_o     = rd_cnt_q;
    assign wr_cnt_o     = wr_cnt_q;
    assign snp_cnt_o    = snp_cnt_q;
endmodule

// File: tb/tb_dcache_txn_monitor.sv
// Directed, table-driven bench for dcache_txn_monitor (3 ports, 16-cycle timeout).
module tb_dcache_txn_monitor;
    import dcache_txn_monitor_pkg::*;

    localparam int NP  = 3;
    localparam int TMO = 16;

    logic                     clk = 1'b0;
    logic                     rst_n;
    dcache_req_i_t [NP-1:0]   req_i;
    dcache_req_o_t [NP-1:0]   req_o;
    snoop_req_t               snp_req;
    snoop_resp_t              snp_resp;
    logic                     check_done, proto_err, timeout;
    logic [1:0]               err_port;
    logic [31:0]              rd_cnt, wr_cnt, snp_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dcache_txn_monitor #(
        .NR_CPU_PORTS (NP),
        .TimeoutCycles(TMO),
        .CntWidth     (32)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_ports_i (req_i),
        .req_ports_o (req_o),
        .snoop_req_i (snp_req),
        .snoop_resp_i(snp_resp),
        .check_done_o(check_done),
        .proto_err_o (proto_err),
        .timeout_o   (timeout),
        .err_port_o  (err_port),
        .rd_cnt_o    (rd_cnt),
        .wr_cnt_o    (wr_cnt),
        .snp_cnt_o   (snp_cnt)
    );

    // snp bits: {ac_valid, ac_ready, cr_valid, cr_ready, DataTransfer, cd_valid, cd_ready, cd_last}
    typedef struct {
        logic [2:0] req, we, gnt, rv, kill;
        logic [7:0] snp;
        logic       exp_done;
        int         exp_rd, exp_wr, exp_snp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [2:0] req, we, gnt, rv, kill,
                                input logic [7:0] snp, input logic d, input int r, w, s);
        vec_t v;
        v.req = req; v.we = we; v.gnt = gnt; v.rv = rv; v.kill = kill; v.snp = snp;
        v.exp_done = d; v.exp_rd = r; v.exp_wr = w; v.exp_snp = s;
        return v;
    endfunction

    task automatic apply(input logic [2:0] req, we, gnt, rv, kill, input logic [7:0] snp);
        for (int i = 0; i < NP; i++) begin
            req_i[i].data_req    = req[i];
            req_i[i].data_we     = we[i];
            req_i[i].kill_req    = kill[i];
            req_o[i].data_gnt    = gnt[i];
            req_o[i].data_rvalid = rv[i];
        end
        snp_req.ac_valid               = snp[7];
        snp_resp.ac_ready              = snp[6];
        snp_resp.cr_valid              = snp[5];
        snp_req.cr_ready               = snp[4];
        snp_resp.cr_resp               = '0;
        snp_resp.cr_resp.DataTransfer  = snp[3];
        snp_resp.cd_valid              = snp[2];
        snp_req.cd_ready               = snp[1];
        snp_resp.cd_last               = snp[0];
    endtask

    // Drive one cycle of inputs, then sample just after the clock edge that consumes them.
    task automatic step(input logic [2:0] req, we, gnt, rv, kill, input logic [7:0] snp);
        @(negedge clk);
        apply(req, we, gnt, rv, kill, snp);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step();
        step(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 8'h00);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        apply(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n_wait;
        logic seen;

        rst_n = 1'b0;
        apply(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check("rst_done", {31'd0, check_done}, 0);
        check("rst_perr", {31'd0, proto_err}, 0);
        check("rst_tmo", {31'd0, timeout}, 0);
        check("rst_eport", {30'd0, err_port}, 0);
        check("rst_rd", rd_cnt, 0);
        check("rst_wr", wr_cnt, 0);
        check("rst_snp", snp_cnt, 0);

        //                 req     we      gnt     rv      kill    snp         done rd wr snp
        vecs.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 8'b00000000, 0, 0, 0, 0));
        vecs.push_back(mk(3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 8'b00000000, 1, 0, 1, 0)); // p0 write req+gnt
        vecs.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 8'b00000000, 0, 0, 1, 0));
        vecs.push_back(mk(3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 8'b00000000, 0, 0, 1, 0)); // p1 read, no gnt
        vecs.push_back(mk(3'b010, 3'b000, 3'b010, 3'b000, 3'b000, 8'b00000000, 0, 0, 1, 0)); // p1 gnt
        vecs.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 8'b00000000, 0, 0, 1, 0));
        vecs.push_back(mk(3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 8'b00000000, 1, 1, 1, 0)); // p1 rvalid
        vecs.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 8'b11000000, 0, 1, 1, 0)); // AC hs
        vecs.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 8'b00111000, 0, 1, 1, 0)); // CR hs, data
        vecs.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 8'b00000110, 0, 1, 1, 0)); // CD beat 1
        vecs.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 8'b00000111, 1, 1, 1, 1)); // CD last
        vecs.push_back(mk(3'b001, 3'b000, 3'b001, 3'b000, 3'b000, 8'b00000000, 0, 1, 1, 1)); // p0 read granted
        vecs.push_back(mk(3'b100, 3'b100, 3'b100, 3'b000, 3'b000, 8'b00000000, 0, 1, 2, 1)); // p2 write, p0 busy
        vecs.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 8'b00000000, 0, 1, 2, 1));
        vecs.push_back(mk(3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 8'b00000000, 1, 2, 2, 1)); // p0 rvalid -> pulse
        vecs.push_back(mk(3'b011, 3'b011, 3'b011, 3'b000, 3'b000, 8'b00000000, 1, 2, 4, 1)); // two writes at once
        vecs.push_back(mk(3'b010, 3'b000, 3'b010, 3'b000, 3'b000, 8'b00000000, 0, 2, 4, 1)); // p1 read granted
        vecs.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 8'b00000000, 0, 2, 4, 1)); // p1 killed
        vecs.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 8'b00000000, 0, 2, 4, 1));
        vecs.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 8'b11000000, 0, 2, 4, 1)); // AC hs
        vecs.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 8'b00110000, 1, 2, 4, 2)); // CR hs, no data
        vecs.push_back(mk(3'b100, 3'b100, 3'b000, 3'b000, 3'b000, 8'b00000000, 0, 2, 4, 2)); // p2 write waits
        vecs.push_back(mk(3'b100, 3'b000, 3'b100, 3'b000, 3'b000, 8'b00000000, 1, 2, 5, 2)); // gnt, we latched

        foreach (vecs[k]) begin
            step(vecs[k].req, vecs[k].we, vecs[k].gnt, vecs[k].rv, vecs[k].kill, vecs[k].snp);
            $display("vec %0d: done=%0b rd=%0d wr=%0d snp=%0d perr=%0b",
                     k, check_done, rd_cnt, wr_cnt, snp_cnt, proto_err);
            check($sformatf("vec%0d_done", k), {31'd0, check_done}, {31'd0, vecs[k].exp_done});
            check($sformatf("vec%0d_rd", k), rd_cnt, vecs[k].exp_rd);
            check($sformatf("vec%0d_wr", k), wr_cnt, vecs[k].exp_wr);
            check($sformatf("vec%0d_snp", k), snp_cnt, vecs[k].exp_snp);
            check($sformatf("vec%0d_perr", k), {31'd0, proto_err}, 0);
        end

        // Exact timing: port 1 req/gnt in cycle 5, rvalid in cycle 8, pulse only in cycle 9.
        do_reset();
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (cyc == 5)      step(3'b010, 3'b000, 3'b010, 3'b000, 3'b000, 8'h00);
            else if (cyc == 8) step(3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 8'h00);
            else               idle_step();
            $display("timing cycle %0d: done=%0b", cyc + 1, check_done);
            check($sformatf("timing_c%0d", cyc + 1), {31'd0, check_done}, (cyc + 1 == 9) ? 32'd1 : 32'd0);
        end
        check("timing_rd", rd_cnt, 1);

        // rvalid on idle port 2, then a snoop error: the first offender sticks.
        do_reset();
        step(3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 8'h00);
        $display("stray rvalid p2: perr=%0b eport=%0d", proto_err, err_port);
        check("stray_perr", {31'd0, proto_err}, 1);
        check("stray_eport", {30'd0, err_port}, 2);
        step(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 8'b00000100);
        $display("stray cd_valid: perr=%0b eport=%0d", proto_err, err_port);
        check("snp_err_perr", {31'd0, proto_err}, 1);
        check("snp_err_eport", {30'd0, err_port}, 2);
        check("snp_err_tmo", {31'd0, timeout}, 0);

        // Timeout on an unanswered read, then reset clears everything mid-operation.
        do_reset();
        step(3'b010, 3'b010, 3'b010, 3'b000, 3'b000, 8'h00);
        check("tmo_pre_wr", wr_cnt, 1);
        step(3'b001, 3'b000, 3'b001, 3'b000, 3'b000, 8'h00);
        repeat (12) idle_step();
        check("tmo_early", {31'd0, timeout}, 0);
        seen = 1'b0;
        n_wait = 12;
        while (!seen && n_wait < 40) begin
            idle_step();
            n_wait++;
            seen = timeout;
        end
        $display("timeout after %0d idle cycles", n_wait);
        check("tmo_set", {31'd0, seen}, 1);
        check("tmo_window", {31'd0, (n_wait >= TMO - 1 && n_wait <= TMO + 3)}, 1);
        step(3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 8'h00);
        check("tmo_gnt_perr", {31'd0, proto_err}, 1);

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        $display("mid-op reset: done=%0b perr=%0b tmo=%0b eport=%0d rd=%0d wr=%0d snp=%0d",
                 check_done, proto_err, timeout, err_port, rd_cnt, wr_cnt, snp_cnt);
        check("mrst_tmo", {31'd0, timeout}, 0);
        check("mrst_perr", {31'd0, proto_err}, 0);
        check("mrst_eport", {30'd0, err_port}, 0);
        check("mrst_wr", wr_cnt, 0);
        check("mrst_done", {31'd0, check_done}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle_step();
            check($sformatf("post_rst_done%0d", i), {31'd0, check_done}, 0);
        end
        step(3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 8'h00);
        $display("post-reset write: done=%0b wr=%0d", check_done, wr_cnt);
        check("post_rst_wr_done", {31'd0, check_done}, 1);
        check("post_rst_wr", wr_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
